// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Purpose:
//   Drives a 4-digit common-anode seven-segment display by time-multiplexing
//   the four digit value/enable pairs coming from the game top. Each digit
//   gets a blanking slot (all anodes off, avoids ghosting) followed by a
//   display slot, round-robin 0 -> 1 -> 2 -> 3. The selected digit's inputs
//   are captured at the BLANK -> SHOW edge, so the pattern on the pins never
//   changes in the middle of a slot.
//
// Parameters:
//   DWELL_CYCLES  clock cycles each digit is lit per slot (>= 1)
//   BLANK_CYCLES  clock cycles all anodes are off before each slot (>= 1)
//   CNT_W         slot counter width, holds max(DWELL,BLANK)-1
//
// Ports:
//   clk_i                 system clock
//   rst_i                 synchronous, active-high reset
//   digitN_en_i (N=0..3)  1 = digit lit, 0 = digit dark
//   digitN_i    (N=0..3)  hex value for digit N
//   lamp_test_i           (only with SEVEN_SEG_LAMP_TEST_EN) force all
//                         segments on for the slot being captured
//   anode_o               active-low digit selects, bit N = digit N
//   segments_o            active-low cathodes, bit order {g,f,e,d,c,b,a}
//   frame_o               one-cycle pulse on the first lit cycle of digit 0
//
// Optional feature macro: SEVEN_SEG_LAMP_TEST_EN
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
`ifdef SEVEN_SEG_LAMP_TEST_EN
  input  logic       lamp_test_i,
`endif
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o,
  output logic       frame_o
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [3:0]       AnodeOff  = 4'b1111;
  localparam logic [6:0]       SegOff    = 7'h7F;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] slotCnt_q;
  logic [3:0]       anode_q;
  logic [6:0]       segments_q;
  logic             frame_q;

  logic             selEn_d;
  logic [3:0]       selVal_d;
  logic [3:0]       showAnode_d;
  logic [6:0]       showSeg_d;

  // Hex to active-low {g,f,e,d,c,b,a}; lower-case b and d keep them
  // distinguishable from 8 and 0.
  function automatic logic [6:0] decodeHex(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  // Pick the digit addressed by the scan index. This is only consumed on
  // the BLANK -> SHOW edge, which is what makes the capture a snapshot.
  always_comb begin
    selEn_d  = digit0_en_i;
    selVal_d = digit0_i;
    case (idx_q)
      2'd0: begin
        selEn_d  = digit0_en_i;
        selVal_d = digit0_i;
      end
      2'd1: begin
        selEn_d  = digit1_en_i;
        selVal_d = digit1_i;
      end
      2'd2: begin
        selEn_d  = digit2_en_i;
        selVal_d = digit2_i;
      end
      default: begin
        selEn_d  = digit3_en_i;
        selVal_d = digit3_i;
      end
    endcase
  end

  // Pattern the display slot will hold. A dark digit keeps its anode high
  // but still occupies its slot so the frame period never changes.
  always_comb begin
    showAnode_d = AnodeOff;
    showSeg_d   = SegOff;
    if (selEn_d) begin
      showAnode_d = ~(4'b0001 << idx_q);
      showSeg_d   = decodeHex(selVal_d);
    end
`ifdef SEVEN_SEG_LAMP_TEST_EN
    if (lamp_test_i) begin
      showAnode_d = ~(4'b0001 << idx_q);
      showSeg_d   = 7'h00;
    end
`endif
  end

  // Scan FSM. Outputs are loaded on the same edge as the state change, so
  // the pins follow the state with no extra cycle and no combinational
  // path from the digit inputs. Reset is checked first, so it wins over a
  // coincident slot boundary.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BLANK;
      idx_q      <= 2'd0;
      slotCnt_q  <= '0;
      anode_q    <= AnodeOff;
      segments_q <= SegOff;
      frame_q    <= 1'b0;
    end else begin
      case (state_q)
        BLANK: begin
          anode_q    <= AnodeOff;
          segments_q <= SegOff;
          frame_q    <= 1'b0;
          if (slotCnt_q == BlankLast) begin
            slotCnt_q  <= '0;
            state_q    <= SHOW;
            anode_q    <= showAnode_d;
            segments_q <= showSeg_d;
            frame_q    <= (idx_q == 2'd0);
          end else begin
            slotCnt_q <= slotCnt_q + 1'b1;
          end
        end
        SHOW: begin
          frame_q <= 1'b0;
          if (slotCnt_q == DwellLast) begin
            slotCnt_q  <= '0;
            state_q    <= BLANK;
            idx_q      <= idx_q + 2'd1;
            anode_q    <= AnodeOff;
            segments_q <= SegOff;
          end else begin
            slotCnt_q <= slotCnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= BLANK;
          slotCnt_q  <= '0;
          anode_q    <= AnodeOff;
          segments_q <= SegOff;
          frame_q    <= 1'b0;
        end
      endcase
    end
  end

  assign anode_o    = anode_q;
  assign segments_o = segments_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Self-checking bench for seven_seg_scanner with DWELL_CYCLES=4 and
// BLANK_CYCLES=2 (slot = 6 cycles, frame = 24 cycles). A reference model
// derives the expected pins from the number of clock edges since reset:
// edge k (k >= 2) lies in slot ((k-2) mod 24)/6 at phase (k-2) mod 6, phases
// 0..3 lit and 4..5 blank, with the digit captured on phase 0. Directed
// sequences and a vector table cover the named corner cases.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dig [4];
  logic       en  [4];
  logic [3:0] anode;
  logic [6:0] seg;
  logic       frame;

  int checks   = 0;
  int failures = 0;

  logic [6:0] decodeRef [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .digit0_en_i(en[0]),
    .digit1_en_i(en[1]),
    .digit2_en_i(en[2]),
    .digit3_en_i(en[3]),
    .digit0_i(dig[0]),
    .digit1_i(dig[1]),
    .digit2_i(dig[2]),
    .digit3_i(dig[3]),
    .anode_o(anode),
    .segments_o(seg),
    .frame_o(frame)
  );

  // Scan position as plain arithmetic on the edge count since reset.
  function automatic int phaseOf(input int k);
    if (k < BLANK) return -1;
    return (k - BLANK) % SLOT;
  endfunction

  function automatic int slotOf(input int k);
    return ((k - BLANK) % FRAME) / SLOT;
  endfunction

  int         mK;
  logic [3:0] mAnode;
  logic [6:0] mSeg;
  logic       mFrame;
  bit         modelValid = 1'b0;

  // Reference model: captures the addressed digit on phase 0, holds through
  // the lit phases, blanks otherwise.
  always @(posedge clk) begin
    if (rst) begin
      mK         <= 0;
      mAnode     <= 4'hF;
      mSeg       <= 7'h7F;
      mFrame     <= 1'b0;
      modelValid <= 1'b1;
    end else begin
      mK <= mK + 1;
      if (phaseOf(mK + 1) == 0) begin
        mAnode <= en[slotOf(mK + 1)] ? 4'hF & ~(4'd1 << slotOf(mK + 1)) : 4'hF;
        mSeg   <= en[slotOf(mK + 1)] ? decodeRef[dig[slotOf(mK + 1)]] : 7'h7F;
        mFrame <= (slotOf(mK + 1) == 0);
      end else if (phaseOf(mK + 1) > 0 && phaseOf(mK + 1) < DWELL) begin
        mFrame <= 1'b0;
      end else begin
        mAnode <= 4'hF;
        mSeg   <= 7'h7F;
        mFrame <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, plus the single-anode rule.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model_anode", 32'(anode), 32'(mAnode));
      checkOutput("model_segments", 32'(seg), 32'(mSeg));
      checkOutput("model_frame", 32'(frame), 32'(mFrame));
      checkOutput("one_anode_max", 32'($countones(~anode) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] v0, input logic [3:0] v1,
                               input logic [3:0] v2, input logic [3:0] v3,
                               input logic [3:0] ens);
    dig[0] = v0;
    dig[1] = v1;
    dig[2] = v2;
    dig[3] = v3;
    for (int n = 0; n < 4; n++) en[n] = ens[n];
  endtask

  // Leaves the bench at the negedge after the reset edge (edge count 0).
  task automatic doReset();
    rst = 1'b1;
    tick();
    checkOutput("reset_anode", 32'(anode), 32'hF);
    checkOutput("reset_segments", 32'(seg), 32'h7F);
    checkOutput("reset_frame", 32'(frame), 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] val;
    logic       en;
    logic [3:0] expAnode;
    logic [6:0] expSeg;
  } vec_t;

  vec_t vecs [18];
  logic [3:0] slotAnode [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] slotSeg   [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

  initial begin
    vecs[0]  = '{4'h0, 1'b1, 4'hE, 7'h40};
    vecs[1]  = '{4'h1, 1'b1, 4'hE, 7'h79};
    vecs[2]  = '{4'h2, 1'b1, 4'hE, 7'h24};
    vecs[3]  = '{4'h3, 1'b1, 4'hE, 7'h30};
    vecs[4]  = '{4'h4, 1'b1, 4'hE, 7'h19};
    vecs[5]  = '{4'h5, 1'b1, 4'hE, 7'h12};
    vecs[6]  = '{4'h6, 1'b1, 4'hE, 7'h02};
    vecs[7]  = '{4'h7, 1'b1, 4'hE, 7'h78};
    vecs[8]  = '{4'h8, 1'b1, 4'hE, 7'h00};
    vecs[9]  = '{4'h9, 1'b1, 4'hE, 7'h10};
    vecs[10] = '{4'hA, 1'b1, 4'hE, 7'h08};
    vecs[11] = '{4'hB, 1'b1, 4'hE, 7'h03};
    vecs[12] = '{4'hC, 1'b1, 4'hE, 7'h46};
    vecs[13] = '{4'hD, 1'b1, 4'hE, 7'h21};
    vecs[14] = '{4'hE, 1'b1, 4'hE, 7'h06};
    vecs[15] = '{4'hF, 1'b1, 4'hE, 7'h0E};
    vecs[16] = '{4'h8, 1'b0, 4'hF, 7'h7F};
    vecs[17] = '{4'h3, 1'b0, 4'hF, 7'h7F};

    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'hF);
    @(negedge clk);

    // Digits 1,2,3,4 all enabled: slot patterns, blanking, frame period.
    $display("[TB] scan order and frame timing");
    doReset();
    for (int k = 1; k <= 50; k++) begin
      tick();
      checkOutput("frame_timing", 32'(frame), 32'(k == 2 || k == 26 || k == 50));
      if (k < 2) begin
        checkOutput("initial_blank", 32'({anode, seg}), 32'({4'hF, 7'h7F}));
      end
      for (int s = 0; s < 4; s++) begin
        if (k == 2 + 6 * s || k == 5 + 6 * s) begin
          checkOutput("slot_anode", 32'(anode), 32'(slotAnode[s]));
          checkOutput("slot_segments", 32'(seg), 32'(slotSeg[s]));
        end
        if (k == 6 + 6 * s || k == 7 + 6 * s) begin
          checkOutput("gap_blank", 32'({anode, seg}), 32'({4'hF, 7'h7F}));
        end
      end
    end

    // Digit 2 dark: its slot stays blank but keeps its length.
    $display("[TB] disabled digit");
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'b1011);
    doReset();
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k >= 14 && k <= 17) begin
        checkOutput("dark_slot", 32'({anode, seg}), 32'({4'hF, 7'h7F}));
      end
      if (k == 20) checkOutput("after_dark_anode", 32'(anode), 32'h7);
      if (k == 26) checkOutput("dark_frame", 32'(frame), 32'h1);
    end

    // Input change mid-slot is ignored until the next capture.
    $display("[TB] mid-slot input change");
    applyStimulus(4'h5, 4'h2, 4'h3, 4'h4, 4'hF);
    doReset();
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 3) dig[0] = 4'h8;
      if (k >= 2 && k <= 5) checkOutput("held_segments", 32'(seg), 32'h12);
      if (k == 26) begin
        checkOutput("next_frame_segments", 32'(seg), 32'h00);
        checkOutput("next_frame_anode", 32'(anode), 32'hE);
      end
    end

    // Reset during the third cycle of digit 2's display slot.
    $display("[TB] reset mid-slot");
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'hF);
    doReset();
    for (int k = 1; k <= 16; k++) tick();
    checkOutput("pre_reset_anode", 32'(anode), 32'hB);
    doReset();
    tick();
    checkOutput("post_reset_blank", 32'({anode, seg}), 32'({4'hF, 7'h7F}));
    tick();
    checkOutput("post_reset_anode", 32'(anode), 32'hE);
    checkOutput("post_reset_segments", 32'(seg), 32'h79);
    checkOutput("post_reset_frame", 32'(frame), 32'h1);

    // Decode table sweep on digit 0, plus dark entries.
    $display("[TB] decode vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].val, 4'h2, 4'h3, 4'h4, {3'b111, vecs[i].en});
      doReset();
      tick();
      tick();
      checkOutput("vec_anode", 32'(anode), 32'(vecs[i].expAnode));
      checkOutput("vec_segments", 32'(seg), 32'(vecs[i].expSeg));
    end

    // Random inputs and occasional resets against the model.
    $display("[TB] randomized run");
    doReset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
